axis_read_cfg_seq: RTL and testbench

AXIS_READ_CFG_SEQ -- requirements
Module: axis_read_cfg_seq

---
 rtl/axis_read_cfg_seq_if.sv | 29 ++
 rtl/axis_read_cfg_seq.sv | 156 +++++++++++++++
 tb/tb_axis_read_cfg_seq.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_read_cfg_seq_if.sv
// Command handshake and config-bus bundle
// shared by axis_read_cfg_seq and its users.
interface axis_read_cfg_seq_if #(
  parameter int CFG_AWIDTH = 5,
  parameter int CFG_DWIDTH = 32
);
  logic [CFG_DWIDTH-1:0] cmd_id;
  logic [CFG_DWIDTH-1:0] cmd_address;
  logic [CFG_DWIDTH-1:0] cmd_length;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [CFG_AWIDTH-1:0] cfg_addr;
  logic [CFG_DWIDTH-1:0] cfg_data;
  logic                  cfg_valid;

  modport master (
    output cmd_id, cmd_address, cmd_length,
    output cmd_valid,
    input  cmd_ready,
    input  cfg_addr, cfg_data, cfg_valid
  );

  modport slave (
    input  cmd_id, cmd_address, cmd_length,
    input  cmd_valid,
    output cmd_ready,
    output cfg_addr, cfg_data, cfg_valid
  );
endinterface

// File: rtl/axis_read_cfg_seq.sv
// Queues stream read commands and replays each
// as three config-bus writes followed by a gap.
module axis_read_cfg_seq #(
  parameter int CFG_AWIDTH = 5,
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_ADDR   = 23,
  parameter int CFG_DATA   = 24,
  parameter int CMD_AWIDTH = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  axis_read_cfg_seq_if.slave  bus,
  output logic                busy,
  output logic [CMD_AWIDTH:0] queued,
  output logic                dropped
);
  localparam int DEPTH = 1 << CMD_AWIDTH;
  localparam int CW    = CMD_AWIDTH + 1;

  typedef struct packed {
    logic [CFG_DWIDTH-1:0] id;
    logic [CFG_DWIDTH-1:0] address;
    logic [CFG_DWIDTH-1:0] length;
  } cmd_t;

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    SEL  = 5'b00010,
    ADDR = 5'b00100,
    LEN  = 5'b01000,
    GAP  = 5'b10000
  } state_t;

  state_t                state, state_nxt;
  cmd_t                  mem [DEPTH];
  cmd_t                  head, cmd_q, cmd_nxt;
  logic [CMD_AWIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_nxt;
  logic                  push, pop, ready_q;
  logic [7:0]            gap_cnt, gap_nxt;
  logic                  v_q, v_nxt;
  logic [CFG_AWIDTH-1:0] a_q, a_nxt;
  logic [CFG_DWIDTH-1:0] d_q, d_nxt;
  logic                  drop_q, drop_nxt;

  assign head      = mem[rd_ptr];
  assign push      = bus.cmd_valid && ready_q;
  assign count_nxt = count + CW'(push) - CW'(pop);

  // ready is registered from the post-update count,
  // so a full queue refuses a push even during a pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= cmd_t'{
          id:      bus.cmd_id,
          address: bus.cmd_address,
          length:  bus.cmd_length
        };
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nxt;
      ready_q <= (count_nxt < CW'(DEPTH));
    end
  end

  // bus registers load the word of the state
  // being entered, so words line up with states
  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd_q;
    gap_nxt   = gap_cnt;
    pop       = 1'b0;
    drop_nxt  = 1'b0;
    v_nxt     = 1'b0;
    a_nxt     = '0;
    d_nxt     = '0;
    unique case (1'b1)
      state[0]: begin
        if (count != '0) begin
          pop = 1'b1;
          if (head.length == '0) begin
            drop_nxt = 1'b1;
          end else begin
            state_nxt = SEL;
            cmd_nxt   = head;
            v_nxt     = 1'b1;
            a_nxt     = CFG_AWIDTH'(CFG_ADDR);
            d_nxt     = head.id;
          end
        end
      end
      state[1]: begin
        state_nxt = ADDR;
        v_nxt     = 1'b1;
        a_nxt     = CFG_AWIDTH'(CFG_DATA);
        d_nxt     = cmd_q.address;
      end
      state[2]: begin
        state_nxt = LEN;
        v_nxt     = 1'b1;
        a_nxt     = CFG_AWIDTH'(CFG_DATA);
        d_nxt     = cmd_q.length;
      end
      state[3]: begin
        state_nxt = GAP;
        gap_nxt   = 8'(GAP_CYCLES);
      end
      state[4]: begin
        if (gap_cnt <= 8'd1)
          state_nxt = IDLE;
        else
          gap_nxt = gap_cnt - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cmd_q   <= '0;
      gap_cnt <= '0;
      v_q     <= 1'b0;
      a_q     <= '0;
      d_q     <= '0;
      drop_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cmd_q   <= cmd_nxt;
      gap_cnt <= gap_nxt;
      v_q     <= v_nxt;
      a_q     <= a_nxt;
      d_q     <= d_nxt;
      drop_q  <= drop_nxt;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.cfg_valid = v_q;
  assign bus.cfg_addr  = a_q;
  assign bus.cfg_data  = d_q;
  assign busy          = (state != IDLE);
  assign queued        = count;
  assign dropped       = drop_q;
endmodule

// File: tb/tb_axis_read_cfg_seq.sv
// Self-checking bench for axis_read_cfg_seq:
// scoreboarded bus words plus timing sequences.
module tb_axis_read_cfg_seq;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CA = 2;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } word_t;

  typedef struct {
    logic [31:0] id;
    logic [31:0] addr;
    logic [31:0] len;
    bit          drop;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        busy;
  logic [CA:0] queued;
  logic        dropped;

  axis_read_cfg_seq_if #(.CFG_AWIDTH(AW), .CFG_DWIDTH(DW)) b ();

  axis_read_cfg_seq #(
    .CFG_AWIDTH(AW), .CFG_DWIDTH(DW),
    .CFG_ADDR(23), .CFG_DATA(24),
    .CMD_AWIDTH(CA), .GAP_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(b),
    .busy(busy), .queued(queued), .dropped(dropped)
  );

  word_t sb [$];
  int    wcyc [$];
  int    n_chk = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    max_q = 0;
  int    drop_cnt = 0;
  vec_t  vecs [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: timeout, expected event", name);
  endtask

  task automatic expect_cmd(input logic [31:0] id,
                            input logic [31:0] a,
                            input logic [31:0] l);
    word_t w;
    if (l == 32'd0) return;
    w.a = 5'd23; w.d = id; sb.push_back(w);
    w.a = 5'd24; w.d = a;  sb.push_back(w);
    w.a = 5'd24; w.d = l;  sb.push_back(w);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      word_t w;
      if (int'(queued) > max_q) max_q = int'(queued);
      if (dropped) drop_cnt++;
      if (b.cfg_valid) begin
        wcyc.push_back(cyc);
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_word: got addr %0d data 0x%0h, expected none",
                   b.cfg_addr, b.cfg_data);
        end else begin
          w = sb.pop_front();
          chk("word_addr", 64'(b.cfg_addr), 64'(w.a));
          chk("word_data", 64'(b.cfg_data), 64'(w.d));
        end
      end else begin
        chk("idle_bus_zero",
            64'({b.cfg_addr, b.cfg_data}), 64'd0);
      end
    end
  end

  // called at posedge+1; returns at posedge+1 of the accepting edge
  task automatic send(input logic [31:0] id,
                      input logic [31:0] a,
                      input logic [31:0] l,
                      input bit hold);
    bit acc;
    int t;
    b.cmd_id      = id;
    b.cmd_address = a;
    b.cmd_length  = l;
    b.cmd_valid   = 1'b1;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 300) begin
      @(negedge clk);
      acc = b.cmd_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) fail_now("send_accept");
    else expect_cmd(id, a, l);
    if (!hold) b.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 500 && !done; t++) begin
      @(negedge clk);
      if (!busy && queued == '0 && sb.size() == 0 &&
          !b.cmd_valid)
        done = 1'b1;
    end
    if (!done) fail_now("wait_idle");
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    int exp_drops;
    vecs[0] = '{32'h11, 32'h0000_0100, 32'h10, 1'b0};
    vecs[1] = '{32'h12, 32'h0000_0200, 32'h00, 1'b1};
    vecs[2] = '{32'h13, 32'h0000_0300, 32'h20, 1'b0};
    vecs[3] = '{32'h00, 32'h0000_0000, 32'h01, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{32'h15, 32'hAAAA_5555, 32'h00, 1'b1};
    vecs[6] = '{32'h16, 32'h5555_AAAA, 32'h00, 1'b1};
    vecs[7] = '{32'h17, 32'h8000_0000, 32'h80, 1'b0};

    rst = 1'b0;
    b.cmd_valid   = 1'b0;
    b.cmd_id      = '0;
    b.cmd_address = '0;
    b.cmd_length  = '0;
    repeat (2) @(negedge clk);
    chk("rst_cfg_valid", 64'(b.cfg_valid), 64'd0);
    chk("rst_cfg_addr", 64'(b.cfg_addr), 64'd0);
    chk("rst_cfg_data", 64'(b.cfg_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_queued", 64'(queued), 64'd0);
    chk("rst_dropped", 64'(dropped), 64'd0);
    chk("rst_ready", 64'(b.cmd_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("ready_before_edge", 64'(b.cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", 64'(b.cmd_ready), 64'd1);

    // single command: bus timing, busy window
    send(32'd1, 32'h1000_0000, 32'h40, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("single_valid_c%0d", k),
          64'(b.cfg_valid), 64'(k >= 2 && k <= 4));
      chk($sformatf("single_busy_c%0d", k),
          64'(busy), 64'(k >= 2 && k <= 8));
      if (k == 1) chk("single_queued", 64'(queued), 64'd1);
    end
    wait_idle();

    // five back-to-back commands, queue fills
    wcyc.delete();
    max_q = 0;
    for (int i = 0; i < 5; i++)
      send(32'h20 + i, 32'h2000_0000 + 32'(i * 256),
           32'(i + 1), i < 4);
    @(negedge clk);
    chk("full_queued", 64'(queued), 64'd4);
    chk("full_ready", 64'(b.cmd_ready), 64'd0);
    found = 1'b0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk);
      if (b.cmd_ready) found = 1'b1;
    end
    if (!found) fail_now("ready_reassert");
    else chk("ready_rise_queued", 64'(queued), 64'd3);
    wait_idle();
    chk("peak_queued", 64'(max_q), 64'd4);
    chk("burst_word_count", 64'(wcyc.size()), 64'd15);
    if (wcyc.size() == 15)
      for (int i = 0; i < 14; i++)
        chk($sformatf("spacing_%0d", i),
            64'(wcyc[i+1] - wcyc[i]),
            (i % 3 == 2) ? 64'd6 : 64'd1);

    // table of commands including zero-length drops
    drop_cnt = 0;
    exp_drops = 0;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].id, vecs[i].addr, vecs[i].len, i < 7);
      if (vecs[i].drop) exp_drops++;
    end
    wait_idle();
    chk("drop_count", 64'(drop_cnt), 64'(exp_drops));

    // inputs changed right after acceptance
    send(32'h7, 32'hABCD_0000, 32'h99, 1'b0);
    b.cmd_id      = 32'hDEAD_BEEF;
    b.cmd_address = 32'hDEAD_BEEF;
    b.cmd_length  = 32'hDEAD_BEEF;
    wait_idle();

    // reset during the ADDR word with two queued
    send(32'h3, 32'h3000_0000, 32'h30, 1'b1);
    send(32'h4, 32'h4000_0000, 32'h40, 1'b1);
    send(32'h5, 32'h5000_0000, 32'h50, 1'b0);
    found = 1'b0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk);
      if (b.cfg_valid && b.cfg_addr == 5'd24) found = 1'b1;
    end
    if (!found) fail_now("find_addr_word");
    chk("pre_rst_queued", 64'(queued), 64'd2);
    rst = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_valid", 64'(b.cfg_valid), 64'd0);
    chk("mid_rst_queued", 64'(queued), 64'd0);
    chk("mid_rst_ready", 64'(b.cmd_ready), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_ready_low", 64'(b.cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("rel_ready_high", 64'(b.cmd_ready), 64'd1);
    repeat (12) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_queued", 64'(queued), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
